pc_gen: RTL and testbench

//   Parametrised fetch program counter for the IF stage; successor to the fixed +4 PC register.

---
 rtl/pc_gen_pkg.sv | 22 ++
 rtl/pc_gen_if.sv | 27 ++
 rtl/pc_gen_redirect_buf.sv | 46 ++++
 rtl/pc_gen.sv | 92 +++++++++
 tb/tb_pc_gen.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch program counter.
// Holds the PC state encodings, the enable/reset levels and the misalignment helper.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PcBoot  = 2'd0,
    PcRun   = 2'd1,
    PcStall = 2'd2
  } pc_state_e;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  // Low address bits below the instruction size must be zero.
  function automatic logic is_misaligned(input logic [63:0] addr, input int unsigned inst_bytes);
    logic [63:0] mask;
    mask = 64'(inst_bytes) - 64'd1;
    return (addr & mask) != 64'd0;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the pipeline control and the PC generator.
// The master drives the stall/ready/redirect inputs; the slave drives the fetch address.
interface pc_gen_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              stall_i;
  logic              if_ready_i;
  logic              branch_i;
  logic [ADDR_W-1:0] branch_pc_i;
  logic              flush_i;
  logic [ADDR_W-1:0] flush_pc_i;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              misalign_o;

  modport master (
    output stall_i, if_ready_i, branch_i, branch_pc_i, flush_i, flush_pc_i,
    input  pc, ce, misalign_o
  );

  modport slave (
    input  stall_i, if_ready_i, branch_i, branch_pc_i, flush_i, flush_pc_i,
    output pc, ce, misalign_o
  );

endinterface

// File: rtl/pc_gen_redirect_buf.sv
// One-entry buffer holding a branch target that arrived while fetch could not fire.
// A new set overwrites the held target; set takes precedence over clear.
module pc_gen_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_pc_i,
  input  logic              clr_i,
  output logic              pend_vld_o,
  output logic [ADDR_W-1:0] pend_pc_o
);

  typedef logic [ADDR_W-1:0] inst_addr_t;

  logic       vld_q, vld_d;
  inst_addr_t pc_q, pc_d;

  always_comb begin
    vld_d = vld_q;
    pc_d  = pc_q;
    if (set_i) begin
      vld_d = 1'b1;
      pc_d  = set_pc_i;
    end else if (clr_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      vld_q <= 1'b0;
      pc_q  <= '0;
    end else begin
      vld_q <= vld_d;
      pc_q  <= pc_d;
    end
  end

  assign pend_vld_o = vld_q;
  assign pend_pc_o  = pc_q;

endmodule

// File: rtl/pc_gen.sv
// IF-stage fetch program counter with reset vector, stall/back-pressure handling,
// buffered branch redirect and flush redirect. All outputs come straight from registers.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       INST_BYTES = 4
) (
  input  logic    clk,
  input  logic    rst,
  pc_gen_if.slave bus
);

  typedef logic [ADDR_W-1:0] inst_addr_t;

  pc_state_e  state_q, state_d;
  inst_addr_t pc_q, pc_d;
  logic       mis_q, mis_d;

  logic       run_en;
  logic       fire;
  logic       pend_vld;
  inst_addr_t pend_pc;
  logic       pend_set;
  logic       pend_clr;

  assign run_en = (state_q != PcBoot);
  assign fire   = run_en & bus.if_ready_i & ~bus.stall_i;

  pc_gen_redirect_buf #(
    .ADDR_W(ADDR_W)
  ) u_redirect_buf (
    .clk       (clk),
    .rst       (rst),
    .set_i     (pend_set),
    .set_pc_i  (bus.branch_pc_i),
    .clr_i     (pend_clr),
    .pend_vld_o(pend_vld),
    .pend_pc_o (pend_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q <= PcBoot;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    case (state_q)
      // Redirects are ignored while booting so the first fetch is always RESET_PC.
      PcBoot: state_d = PcRun;
      PcRun, PcStall: begin
        state_d = fire ? PcRun : PcStall;
        if (bus.flush_i) begin
          pc_d     = bus.flush_pc_i;
          pend_clr = 1'b1;
        end else if (fire) begin
          if (bus.branch_i) begin
            pc_d = bus.branch_pc_i;
          end else if (pend_vld) begin
            pc_d = pend_pc;
          end else begin
            pc_d = pc_q + ADDR_W'(INST_BYTES);
          end
          pend_clr = 1'b1;
        end else if (bus.branch_i) begin
          pend_set = 1'b1;
        end
      end
      default: state_d = PcBoot;
    endcase
    mis_d = is_misaligned(64'(pc_d), INST_BYTES);
  end

  always_comb begin
    bus.ce         = run_en ? ChipEnable : ChipDisable;
    bus.pc         = pc_q;
    bus.misalign_o = mis_q;
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a transaction-level fetch model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pc_gen;

  localparam int unsigned ADDR_W     = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_1000;
  localparam int unsigned INST_BYTES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(ADDR_W)) bus ();

  pc_gen #(
    .ADDR_W    (ADDR_W),
    .RESET_PC  (RESET_PC),
    .INST_BYTES(INST_BYTES)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Fetch model: booting flag, current address, and a queue holding at most one pending target.
  bit          m_boot = 1'b1;
  logic [31:0] m_pc   = RESET_PC;
  logic [31:0] m_pend[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_boot = 1'b1;
      m_pc   = RESET_PC;
      m_pend.delete();
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      if (bus.flush_i) begin
        m_pc = bus.flush_pc_i;
        m_pend.delete();
      end else if (bus.if_ready_i && !bus.stall_i) begin
        if (bus.branch_i)         m_pc = bus.branch_pc_i;
        else if (m_pend.size > 0) m_pc = m_pend[0];
        else                      m_pc = m_pc + INST_BYTES;
        m_pend.delete();
      end else if (bus.branch_i) begin
        m_pend.delete();
        m_pend.push_back(bus.branch_pc_i);
      end
    end
  end

  // Literal expectations posted by the stimulus, consumed by the compare process.
  logic [31:0] lit_pc;
  logic        lit_ce;
  logic        lit_mis;
  string       lit_name;
  int          lit_seq  = 0;
  int          lit_done = 0;

  always @(negedge clk) begin
    logic exp_ce, exp_mis;
    exp_ce  = !m_boot;
    exp_mis = (m_pc % INST_BYTES) != 0;
    n_cmp++;
    if (bus.pc !== m_pc || bus.ce !== exp_ce || bus.misalign_o !== exp_mis) begin
      n_err++;
      $display("FAIL model @%0t: pc=%h ce=%b mis=%b, required pc=%h ce=%b mis=%b", $time,
               bus.pc, bus.ce, bus.misalign_o, m_pc, exp_ce, exp_mis);
    end
    if (lit_seq != lit_done) begin
      lit_done = lit_seq;
      n_cmp++;
      if (bus.pc !== lit_pc || bus.ce !== lit_ce || bus.misalign_o !== lit_mis) begin
        n_err++;
        $display("FAIL %s: pc=%h ce=%b mis=%b, required pc=%h ce=%b mis=%b", lit_name,
                 bus.pc, bus.ce, bus.misalign_o, lit_pc, lit_ce, lit_mis);
      end
    end
  end

  task automatic expect_lit(input logic [31:0] p, input logic c, input logic m, input string nm);
    lit_pc   = p;
    lit_ce   = c;
    lit_mis  = m;
    lit_name = nm;
    lit_seq++;
  endtask

  // Advance one clock; redirect pulses last exactly one cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.branch_i = 1'b0;
    bus.flush_i  = 1'b0;
  endtask

  task automatic branch(input logic [31:0] t);
    bus.branch_i    = 1'b1;
    bus.branch_pc_i = t;
  endtask

  task automatic flush(input logic [31:0] t);
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = t;
  endtask

  initial begin
    bus.stall_i     = 1'b0;
    bus.if_ready_i  = 1'b1;
    bus.branch_i    = 1'b0;
    bus.branch_pc_i = '0;
    bus.flush_i     = 1'b0;
    bus.flush_pc_i  = '0;

    // Reset release and sequential fetch.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_lit(32'h0000_1000, 1'b0, 1'b0, "boot_ce_low");
    tick(); expect_lit(32'h0000_1000, 1'b1, 1'b0, "first_fetch");
    tick(); expect_lit(32'h0000_1004, 1'b1, 1'b0, "seq_plus4");
    tick(); expect_lit(32'h0000_1008, 1'b1, 1'b0, "seq_plus8");

    // Stall holds pc with ce high.
    branch(32'h0000_0100);
    tick(); expect_lit(32'h0000_0100, 1'b1, 1'b0, "branch_fire");
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_lit(32'h0000_0100, 1'b1, 1'b0, "stall_hold");
    end
    bus.stall_i = 1'b0;
    tick(); expect_lit(32'h0000_0104, 1'b1, 1'b0, "stall_release");

    // Branch under back-pressure is buffered and applied on the next fire.
    branch(32'h0000_0200);
    tick(); expect_lit(32'h0000_0200, 1'b1, 1'b0, "branch_0x200");
    bus.if_ready_i = 1'b0;
    branch(32'h0000_0400);
    tick(); expect_lit(32'h0000_0200, 1'b1, 1'b0, "notready_hold");
    tick(); expect_lit(32'h0000_0200, 1'b1, 1'b0, "notready_hold2");
    bus.if_ready_i = 1'b1;
    tick(); expect_lit(32'h0000_0400, 1'b1, 1'b0, "pend_applied");
    tick(); expect_lit(32'h0000_0404, 1'b1, 1'b0, "pend_cleared");

    // Flush beats a simultaneous branch.
    flush(32'hBFC0_0380);
    branch(32'h0000_0500);
    tick(); expect_lit(32'hBFC0_0380, 1'b1, 1'b0, "flush_wins");
    tick(); expect_lit(32'hBFC0_0384, 1'b1, 1'b0, "after_flush");

    // Flush without fire redirects at once and drops the pending target.
    bus.if_ready_i = 1'b0;
    branch(32'h0000_0600);
    tick(); expect_lit(32'hBFC0_0384, 1'b1, 1'b0, "pend_0x600");
    flush(32'h8000_0180);
    tick(); expect_lit(32'h8000_0180, 1'b1, 1'b0, "flush_nofire");
    bus.if_ready_i = 1'b1;
    tick(); expect_lit(32'h8000_0184, 1'b1, 1'b0, "flush_drops_pend");

    // Youngest pending branch wins.
    bus.if_ready_i = 1'b0;
    branch(32'h0000_0700);
    tick();
    branch(32'h0000_0740);
    tick(); expect_lit(32'h8000_0184, 1'b1, 1'b0, "pend_overwrite_hold");
    bus.if_ready_i = 1'b1;
    tick(); expect_lit(32'h0000_0740, 1'b1, 1'b0, "pend_youngest");

    // Address wrap.
    branch(32'hFFFF_FFFC);
    tick(); expect_lit(32'hFFFF_FFFC, 1'b1, 1'b0, "pre_wrap");
    tick(); expect_lit(32'h0000_0000, 1'b1, 1'b0, "wrap");

    // Misaligned target.
    branch(32'h0000_0302);
    tick(); expect_lit(32'h0000_0302, 1'b1, 1'b1, "misalign");
    tick(); expect_lit(32'h0000_0306, 1'b1, 1'b1, "misalign_seq");

    // Reset mid-stall with a pending target.
    bus.stall_i = 1'b1;
    branch(32'h0000_0900);
    tick(); expect_lit(32'h0000_0306, 1'b1, 1'b1, "stall_pend");
    #1 rst = 1'b1;
    expect_lit(RESET_PC, 1'b0, 1'b0, "async_reset");
    tick();
    bus.stall_i = 1'b0;
    rst = 1'b0;
    flush(32'h0000_5000);
    expect_lit(RESET_PC, 1'b0, 1'b0, "boot_flush_ignored");
    tick(); expect_lit(RESET_PC, 1'b1, 1'b0, "refetch_reset_pc");
    tick(); expect_lit(32'h0000_1004, 1'b1, 1'b0, "pend_dropped");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
